// File: rtl/ks_pkg.sv
// Shared Kogge-Stone types and helpers, also used by the downstream sum stage.
package ks_pkg;

  localparam int KS_WIDTH = 16;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int ks_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_pipe_black_box.sv
// Kogge-Stone prefix operator cell, purely combinational.
module black_box (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic g,
  output logic p
);

  assign g = gi | (pi & gj);
  assign p = pi & pj;

endmodule

// File: rtl/ks_prefix_pipe.sv
// Pipelined Kogge-Stone carry prefix: stage 0 forms g/p, then one register per level; latency LEVELS+1.
// Backpressure stalls the whole pipe (en = !out_valid | out_ready); bubbles are kept, never compressed.
module ks_prefix_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] h_out,
  output logic [WIDTH-1:0] p_out,
  output logic             cin_out
);

  localparam int LEVELS = ks_log2(WIDTH);

  logic             en;
  logic [LEVELS:0]  vld_q;
  logic [LEVELS:0]  cin_q;
  logic [WIDTH-1:0] p_q  [LEVELS+1];
  gp_t              gp_q [LEVELS+1][WIDTH];
  gp_t              gp_d [LEVELS+1][WIDTH];
  logic [WIDTH-1:0] final_p_unused;

  assign out_valid = vld_q[LEVELS];
  // rst forces ready so the first reset cycle also reports an empty pipe
  assign en        = rst | ~out_valid | out_ready;
  assign in_ready  = en;

  genvar k, i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage0
      if (i == 0) begin : g_cin
        // cin acts as a generate at position -1
        assign gp_d[0][i] = gp_t'{g: (a[0] & b[0]) | ((a[0] ^ b[0]) & cin), p: a[0] ^ b[0]};
      end else begin : g_plain
        assign gp_d[0][i] = gp_t'{g: a[i] & b[i], p: a[i] ^ b[i]};
      end
    end

    for (k = 1; k <= LEVELS; k++) begin : g_level
      for (i = 0; i < WIDTH; i++) begin : g_cell
        if (i >= (1 << (k - 1))) begin : g_op
          logic g_n;
          logic p_n;
          black_box u_bb (
            .gi(gp_q[k-1][i].g),
            .pi(gp_q[k-1][i].p),
            .gj(gp_q[k-1][i-(1<<(k-1))].g),
            .pj(gp_q[k-1][i-(1<<(k-1))].p),
            .g (g_n),
            .p (p_n)
          );
          assign gp_d[k][i] = gp_t'{g: g_n, p: p_n};
        end else begin : g_pass
          assign gp_d[k][i] = gp_q[k-1][i];
        end
      end
    end

    // group propagate of the last level has no consumer
    for (i = 0; i < WIDTH; i++) begin : g_final
      assign final_p_unused[i] = gp_q[LEVELS][i].p;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cin_q <= '0;
      for (int s = 0; s <= LEVELS; s++) begin
        p_q[s] <= '0;
        for (int j = 0; j < WIDTH; j++) gp_q[s][j] <= '0;
      end
    end else if (en) begin
      vld_q  <= {vld_q[LEVELS-1:0], in_valid};
      cin_q  <= {cin_q[LEVELS-1:0], cin};
      p_q[0] <= a ^ b;
      for (int s = 1; s <= LEVELS; s++) p_q[s] <= p_q[s-1];
      for (int s = 0; s <= LEVELS; s++) begin
        for (int j = 0; j < WIDTH; j++) gp_q[s][j] <= gp_d[s][j];
      end
    end
  end

  always_comb begin
    h_out = '0;
    for (int j = 0; j < WIDTH; j++) h_out[j] = gp_q[LEVELS][j].g;
  end

  assign p_out   = p_q[LEVELS];
  assign cin_out = cin_q[LEVELS];

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Directed bench for ks_prefix_pipe at WIDTH=16: reset, latency, streaming, stall and flush.
module tb_ks_prefix_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cin_out;
  logic [W-1:0] a, b, h_out, p_out;
  int           tests = 0;
  int           fails = 0;
  int           nv, got;

  logic [W-1:0] sa [8] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hAAAA, 16'h0F0F, 16'hFFFE};
  logic [W-1:0] sb [8] = '{16'h0001, 16'h4321, 16'h0000, 16'h8000, 16'h0001, 16'h5555, 16'hF0F0, 16'h0001};
  logic         sc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  ks_prefix_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .h_out    (h_out),
    .p_out    (p_out),
    .cin_out  (cin_out)
  );

  // ripple-carry reference for the carry-out of every bit
  function automatic logic [W-1:0] ref_h(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] r;
    logic         cc;
    cc = c;
    for (int n = 0; n < W; n++) begin
      cc   = (x[n] & y[n]) | ((x[n] ^ y[n]) & cc);
      r[n] = cc;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] sum, esum;
    sum  = {h_out[W-1], p_out ^ {h_out[W-2:0], cin_out}};
    esum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".h"},   h_out, ref_h(x, y, c));
    chk({tag, ".p"},   p_out, x ^ y);
    chk({tag, ".cin"}, cin_out, c);
    chk({tag, ".sum"}, sum, esum);
  endtask

  task automatic single(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] eh, input logic [W-1:0] ep);
    a = x; b = y; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      chk({tag, ".early"}, out_valid, 0);
      step();
    end
    chk({tag, ".vld5"}, out_valid, 1);
    chk({tag, ".h_hand"}, h_out, eh);
    chk({tag, ".p_hand"}, p_out, ep);
    chk({tag, ".cin_hand"}, cin_out, c);
    chk_out(tag, x, y, c);
    step();
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst.in_ready", in_ready, 1);
    step();
    step();
    chk("rst.out_valid", out_valid, 0);
    chk("rst.h_out", h_out, 0);
    chk("rst.p_out", p_out, 0);
    chk("rst.cin_out", cin_out, 0);
    chk("rst.in_ready2", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      chk("rst.discard", out_valid, 0);
      step();
    end

    single("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFE);
    single("incr",     16'h00FF, 16'h0000, 1'b1, 16'h00FF, 16'h00FF);
    single("fullprop", 16'h5555, 16'hAAAA, 1'b1, 16'hFFFF, 16'hFFFF);
    single("zero",     16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // eight back-to-back operations
    nv = 0;
    a = sa[0]; b = sb[0]; cin = sc[0]; in_valid = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (out_valid) nv++;
      if (e >= 5 && e <= 12) chk_out($sformatf("stream%0d", e - 5), sa[e-5], sb[e-5], sc[e-5]);
      else chk($sformatf("stream.idle%0d", e), out_valid, 0);
      if (e <= 7) begin
        a = sa[e]; b = sb[e]; cin = sc[e];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream.count", nv, 8);

    // stall with the output held for three cycles
    a = sa[4]; b = sb[4]; cin = sc[4]; in_valid = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e <= 3) begin
        a = sa[4+e]; b = sb[4+e]; cin = sc[4+e];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk_out("bp.first", sa[4], sb[4], sc[4]);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp.in_ready%0d", n), in_ready, 0);
      step();
      chk_out($sformatf("bp.hold%0d", n), sa[4], sb[4], sc[4]);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    got = 1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (out_valid) begin
        if (got < 4) chk_out($sformatf("bp.rx%0d", got), sa[4+got], sb[4+got], sc[4+got]);
        else chk("bp.extra", out_valid, 0);
        got++;
      end
    end
    chk("bp.count", got, 4);

    // reset with three operations in flight
    a = sa[0]; b = sb[0]; cin = sc[0]; in_valid = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      if (e <= 2) begin
        a = sa[e]; b = sb[e]; cin = sc[e];
      end
    end
    rst = 1'b1;
    #1;
    chk("flush.in_ready_rst", in_ready, 1);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("flush.h_out", h_out, 0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("flush.vld%0d", n), out_valid, 0);
      chk($sformatf("flush.rdy%0d", n), in_ready, 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ks_prefix_pipe.md
KS_PREFIX_PIPE -- requirements
Module: ks_prefix_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width; legal values 4, 8, 16, 32, 64 (powers of two).
REQ-002 SHALL have localparam LEVELS = log2(WIDTH), the number of Kogge-Stone prefix levels.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a, b and cin are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in (1 with b=0 gives increment).
REQ-009 SHALL have port out_valid, output, 1 bit: h_out, p_out and cin_out are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream sum stage accepts the output.
REQ-011 SHALL have port h_out, output, WIDTH bits: h_out[i] is the carry out of bit i, including cin.
REQ-012 SHALL have port p_out, output, WIDTH bits: p_out[i] = a[i]^b[i].
REQ-013 SHALL have port cin_out, output, 1 bit: cin delayed to align with h_out and p_out.

Function
REQ-014 Stage 0 SHALL register g=a&b and p=a^b; cin SHALL be folded in as a generate at position -1, so that g'[0]=g[0]|(p[0]&cin).
REQ-015 Prefix level k (1..LEVELS) SHALL register, for i >= 2^(k-1), G=Gi|(Pi&Gj) and P=Pi&Pj with j=i-2^(k-1); other positions SHALL pass through unchanged.
REQ-016 Latency SHALL be LEVELS+1 cycles from an accepted input to out_valid (5 for WIDTH=16).
REQ-017 The original p vector and cin SHALL travel alongside each prefix stage unchanged and emerge as p_out and cin_out.
REQ-018 The pipeline advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en.
REQ-019 When en=1, all stages SHALL shift one position and stage 0 SHALL capture valid=in_valid.
REQ-020 When en=0, every data and valid register SHALL hold, and input SHALL be ignored.
REQ-021 Sustained throughput SHALL be one operation per cycle while out_ready=1.
REQ-022 Bubbles SHALL propagate as valid=0 slots; they are not compressed.
REQ-023 out_valid SHALL remain asserted, with h_out, p_out and cin_out stable, until the cycle where out_ready=1.
REQ-024 Data registers of invalid slots are don't-care but SHALL NOT be X after reset.
REQ-025 Arithmetic SHALL be unsigned; the final carry-out equals h_out[WIDTH-1], and no bits are dropped.

Reset
REQ-026 While rst=1, all valid bits SHALL clear to 0 on the clock edge, so out_valid=0 the following cycle.
REQ-027 While rst=1, all data registers SHALL clear to 0: h_out=0, p_out=0, cin_out=0.
REQ-028 While rst=1, in_ready SHALL be 1 (pipeline empty); input presented during reset SHALL be discarded.
REQ-029 Reset asserted mid-operation SHALL flush all in-flight operations; none SHALL emerge afterward.

Structure
REQ-030 A shared package ks_pkg SHALL hold the default WIDTH constant, the log2 helper function, and the gp_t struct {g, p}, shared with the downstream sum stage.
REQ-031 The prefix operator SHALL be one combinational sub-module black_box (inputs Gi, Pi, Gj, Pj; outputs G, P), instantiated per cell per level via generate.
REQ-032 All registers SHALL reside in ks_prefix_pipe; black_box SHALL contain no state.

Verification
REQ-033 WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> after 5 cycles, h_out=0xFFFF, p_out=0xFFFE, cin_out=0 (sum 0x0000, carry-out 1).
REQ-034 Increment: a=0x00FF, b=0, cin=1 -> h_out=0x00FF, p_out=0x00FF, cin_out=1 (sum 0x0100).
REQ-035 Full propagate: a=0x5555, b=0xAAAA, cin=1 -> h_out=0xFFFF, p_out=0xFFFF.
REQ-036 Stream 8 back-to-back operations with out_ready=1 -> 8 consecutive out_valid cycles, in order, starting at cycle 5.
REQ-037 Hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs stable, and no loss or duplication after release.
REQ-038 Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 for the following 5 cycles, and in_ready=1.
